// File: rtl/dff_cmd_ctrl.sv
// Command front end for the set/clear/load flip-flop cell: synchronizes and debounces
// three push-buttons, then issues one-hot single-cycle commands plus the load data bit.
module dff_cmd_ctrl #(
  parameter int DB_COUNT = 500000,
  parameter int CNT_W    = 20
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_ld,
  input  logic btn_st,
  input  logic btn_clr,
  input  logic sw_d,
  output logic d_o,
  output logic ld_o,
  output logic st_o,
  output logic clr_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_COUNT - 1);

  // Bit order in every channel vector: [0]=load, [1]=set, [2]=clear, [3]=data switch.
  logic [3:0] sync_p0, sync_p1;
  logic [2:0] stable_p2, stable_p3;
  logic [2:0] rise;
  logic       win_ld, win_st, win_clr;

  // Stage p0/p1: two-flop synchronizers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {sw_d, btn_clr, btn_st, btn_ld};
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: per-button debounce
  for (genvar g = 0; g < 3; g++) begin : g_db
    logic [CNT_W-1:0] cnt;
    logic             stable;

    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        cnt    <= '0;
        stable <= 1'b0;
      end else if (sync_p1[g] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign stable_p2[g] = stable;
  end

  // Rising edges of the debounced buttons, clear beats set beats load
  always_comb begin
    rise    = stable_p2 & ~stable_p3;
    win_clr = 1'b0;
    win_st  = 1'b0;
    win_ld  = 1'b0;
    if (rise[2])      win_clr = 1'b1;
    else if (rise[1]) win_st  = 1'b1;
    else if (rise[0]) win_ld  = 1'b1;
  end

  // Stage p3: edge history and command output register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stable_p3 <= '0;
      ld_o      <= 1'b0;
      st_o      <= 1'b0;
      clr_o     <= 1'b0;
      d_o       <= 1'b0;
    end else begin
      stable_p3 <= stable_p2;
      ld_o      <= win_ld;
      st_o      <= win_st;
      clr_o     <= win_clr;
      if (win_ld) d_o <= sync_p1[3];
    end
  end

endmodule

// File: tb/tb_dff_cmd_ctrl.sv
// Bench for dff_cmd_ctrl: directed scenarios plus random button traffic, each cycle
// compared against a window-based behavioural model of debounce and arbitration.
module tb_dff_cmd_ctrl;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic clr, btn_ld, btn_st, btn_clr, sw_d;
  logic d_o, ld_o, st_o, clr_o;

  always #5 clk = ~clk;

  dff_cmd_ctrl #(.DB_COUNT(DB), .CNT_W(4)) dut (
    .clk(clk), .clr(clr), .btn_ld(btn_ld), .btn_st(btn_st), .btn_clr(btn_clr),
    .sw_d(sw_d), .d_o(d_o), .ld_o(ld_o), .st_o(st_o), .clr_o(clr_o)
  );

  int tests = 0;
  int fails = 0;

  // Model state: raw two-edge delay line, window of recent synced samples, debounced levels.
  logic [3:0] rawq[$];
  logic [3:0] synh[$];
  logic [2:0] m_stable, m_stable_old;
  logic       m_d, m_ld, m_st, m_clr;

  int   ecnt, n_ld, n_st, n_clr, at_ld, at_st, at_clr;
  logic d_at_ld;

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rawq.delete();
    synh.delete();
    m_stable     = '0;
    m_stable_old = '0;
    m_d   = 1'b0;
    m_ld  = 1'b0;
    m_st  = 1'b0;
    m_clr = 1'b0;
  endtask

  // A button's debounced level flips once its last DB synced samples all disagree with it.
  task automatic model_edge();
    logic [3:0] syn;
    logic [2:0] rise;
    bit         all_diff;
    if (clr) begin
      model_reset();
      return;
    end
    syn = (rawq.size() == 2) ? rawq[0] : 4'b0;
    rawq.push_back({sw_d, btn_clr, btn_st, btn_ld});
    if (rawq.size() > 2) void'(rawq.pop_front());
    synh.push_back(syn);
    if (synh.size() > DB) void'(synh.pop_front());
    rise  = m_stable & ~m_stable_old;
    m_clr = rise[2];
    m_st  = rise[1] && !rise[2];
    m_ld  = rise[0] && (rise[2:1] == 2'b00);
    if (m_ld) m_d = syn[3];
    m_stable_old = m_stable;
    for (int ch = 0; ch < 3; ch++) begin
      all_diff = (synh.size() == DB);
      foreach (synh[k]) if (synh[k][ch] == m_stable[ch]) all_diff = 1'b0;
      if (all_diff) m_stable[ch] = ~m_stable[ch];
    end
  endtask

  task automatic clear_counts();
    ecnt = 0; n_ld = 0; n_st = 0; n_clr = 0;
    at_ld = -1; at_st = -1; at_clr = -1;
    d_at_ld = 1'bx;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    ecnt++;
    check("model d_o", d_o, m_d);
    check("model ld_o", ld_o, m_ld);
    check("model st_o", st_o, m_st);
    check("model clr_o", clr_o, m_clr);
    if (ld_o === 1'b1) begin n_ld++; at_ld = ecnt; d_at_ld = d_o; end
    if (st_o === 1'b1) begin n_st++; at_st = ecnt; end
    if (clr_o === 1'b1) begin n_clr++; at_clr = ecnt; end
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic async_reset_on(input string tag);
    #1;
    clr = 1'b1;
    model_reset();
    #1;
    check({tag, " d_o"}, d_o, 1'b0);
    check({tag, " ld_o"}, ld_o, 1'b0);
    check({tag, " st_o"}, st_o, 1'b0);
    check({tag, " clr_o"}, clr_o, 1'b0);
  endtask

  initial begin
    clr = 1'b1; btn_ld = 1'b0; btn_st = 1'b0; btn_clr = 1'b0; sw_d = 1'b0;
    model_reset();
    clear_counts();
    steps(2);
    check("reset d_o", d_o, 1'b0);
    check("reset ld_o", ld_o, 1'b0);
    check("reset st_o", st_o, 1'b0);
    check("reset clr_o", clr_o, 1'b0);
    clr = 1'b0;
    steps(3);

    // Single load press
    clear_counts();
    sw_d = 1'b1; btn_ld = 1'b1;
    steps(20);
    check_int("single ld count", n_ld, 1);
    check_int("single ld edge", at_ld, 7);
    check("single d_o at ld", d_at_ld, 1'b1);
    check_int("single st count", n_st, 0);
    check_int("single clr count", n_clr, 0);
    btn_ld = 1'b0;
    steps(10);

    // Bouncing set button
    clear_counts();
    for (int r = 0; r < 5; r++) begin
      btn_st = 1'b1; steps(2);
      btn_st = 1'b0; steps(1);
    end
    check_int("bounce st during bounce", n_st, 0);
    clear_counts();
    btn_st = 1'b1;
    steps(15);
    check_int("bounce st count", n_st, 1);
    check_int("bounce st edge", at_st, 7);
    btn_st = 1'b0;
    steps(10);

    // Simultaneous set and clear
    clear_counts();
    btn_st = 1'b1; btn_clr = 1'b1;
    steps(15);
    check_int("simul clr count", n_clr, 1);
    check_int("simul clr edge", at_clr, 7);
    check_int("simul st count", n_st, 0);
    btn_st = 1'b0; btn_clr = 1'b0;
    steps(10);

    // Data capture only on load
    clear_counts();
    sw_d = 1'b0; btn_ld = 1'b1;
    steps(12);
    check_int("capture ld0 count", n_ld, 1);
    check("capture d_o at ld0", d_at_ld, 1'b0);
    btn_ld = 1'b0;
    steps(10);
    sw_d = 1'b1;
    clear_counts();
    btn_st = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("capture d_o held over st", d_o, 1'b0);
    end
    check_int("capture st count", n_st, 1);
    btn_st = 1'b0;
    steps(10);
    check("capture d_o before ld1", d_o, 1'b0);
    clear_counts();
    btn_ld = 1'b1;
    steps(12);
    check_int("capture ld1 count", n_ld, 1);
    check("capture d_o at ld1", d_at_ld, 1'b1);
    btn_ld = 1'b0;
    steps(10);

    // Reset in the middle of debounce, button held through it
    clear_counts();
    btn_ld = 1'b1;
    steps(5);
    async_reset_on("rst mid-debounce");
    steps(4);
    clr = 1'b0;
    clear_counts();
    steps(10);
    check_int("rst held ld count", n_ld, 1);
    check_int("rst held ld edge", at_ld, 7);
    async_reset_on("rst stable");
    steps(2);
    clr = 1'b0;
    clear_counts();
    steps(7);
    check("pulse before async reset", ld_o, 1'b1);
    async_reset_on("rst during pulse");
    steps(2);
    clr = 1'b0;
    btn_ld = 1'b0;
    steps(10);

    // Long hold, short release is ignored, full release then re-press
    clear_counts();
    btn_clr = 1'b1;
    steps(100);
    check_int("held clr count", n_clr, 1);
    check_int("held clr edge", at_clr, 7);
    btn_clr = 1'b0;
    steps(2);
    btn_clr = 1'b1;
    steps(12);
    check_int("short release no repress", n_clr, 1);
    btn_clr = 1'b0;
    steps(10);
    clear_counts();
    btn_clr = 1'b1;
    steps(12);
    check_int("repress clr count", n_clr, 1);
    check_int("repress clr edge", at_clr, 7);
    btn_clr = 1'b0;
    steps(10);

    // Random traffic on all inputs
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) btn_ld  = ~btn_ld;
      if ($urandom_range(0, 5) == 0) btn_st  = ~btn_st;
      if ($urandom_range(0, 5) == 0) btn_clr = ~btn_clr;
      sw_d = 1'($urandom_range(0, 1));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
